// File: rtl/alu_result_stage_pkg.sv
// Shared widths, condition-code constants and the writeback entry type for
// the ALU result / writeback stage.
package alu_result_stage_pkg;

    localparam int DATA_WIDTH     = 16;
    localparam int REG_ADDR_WIDTH = 3;
    localparam int PC_WIDTH       = 16;

    // Condition-code bit positions inside the {n,z,p} vector and branch mask.
    localparam int BR_N = 2;
    localparam int BR_Z = 1;
    localparam int BR_P = 0;

    localparam logic [2:0] CC_RESET = 3'b010;

    typedef struct packed {
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic [DATA_WIDTH-1:0]     data;
    } wb_entry_t;

    function automatic logic br_eval(input logic [2:0] mask, input logic [2:0] cc);
        return |(mask & cc);
    endfunction

endpackage

// File: rtl/alu_result_stage_if.sv
// Upstream (ALU result) and downstream (register-file writeback) handshake
// bundle of the result stage.
interface alu_result_stage_if;
    import alu_result_stage_pkg::*;

    logic                      in_valid;
    logic                      in_ready;
    logic [DATA_WIDTH-1:0]     in_result;
    logic                      in_n;
    logic                      in_z;
    logic                      in_p;
    logic [REG_ADDR_WIDTH-1:0] in_rd;
    logic                      in_we;
    logic                      in_set_cc;
    logic                      in_br;
    logic [2:0]                in_br_mask;
    logic [PC_WIDTH-1:0]       in_br_target;

    logic                      out_valid;
    logic                      out_ready;
    logic [REG_ADDR_WIDTH-1:0] out_rd;
    logic [DATA_WIDTH-1:0]     out_data;

    modport master (
        output in_valid, in_result, in_n, in_z, in_p, in_rd, in_we,
               in_set_cc, in_br, in_br_mask, in_br_target, out_ready,
        input  in_ready, out_valid, out_rd, out_data
    );

    modport slave (
        input  in_valid, in_result, in_n, in_z, in_p, in_rd, in_we,
               in_set_cc, in_br, in_br_mask, in_br_target, out_ready,
        output in_ready, out_valid, out_rd, out_data
    );

endinterface

// File: rtl/alu_result_stage_wb_fifo2.sv
// Two-entry valid/ready elastic buffer. The head always lives in slot0, so
// the output is a plain register and stays stable while stalled.
module wb_fifo2 #(
    parameter int WIDTH = 19
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_valid,
    output logic             push_ready,
    input  logic [WIDTH-1:0] push_data,
    output logic             pop_valid,
    input  logic             pop_ready,
    output logic [WIDTH-1:0] pop_data
);

    logic [1:0]       count_r;
    logic [WIDTH-1:0] slot0_r;
    logic [WIDTH-1:0] slot1_r;
    logic             push_s;
    logic             pop_s;

    assign push_ready = (count_r != 2'd2);
    assign pop_valid  = (count_r != 2'd0);
    assign pop_data   = slot0_r;
    assign push_s     = push_valid && push_ready;
    assign pop_s      = pop_valid && pop_ready;

    // Occupancy and slot update; a pop only shifts when a second entry exists.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= 2'd0;
            slot0_r <= {WIDTH{1'b0}};
            slot1_r <= {WIDTH{1'b0}};
        end else begin
            case ({push_s, pop_s})
                2'b10: begin
                    if (count_r == 2'd0) begin
                        slot0_r <= push_data;
                    end else begin
                        slot1_r <= push_data;
                    end
                    count_r <= count_r + 2'd1;
                end
                2'b01: begin
                    if (count_r == 2'd2) begin
                        slot0_r <= slot1_r;
                    end else begin
                        slot0_r <= slot0_r;
                    end
                    count_r <= count_r - 2'd1;
                end
                2'b11: begin
                    if (count_r == 2'd1) begin
                        slot0_r <= push_data;
                    end else begin
                        slot0_r <= slot1_r;
                        slot1_r <= push_data;
                    end
                end
                default: begin
                    count_r <= count_r;
                end
            endcase
        end
    end

endmodule

// File: rtl/alu_result_stage.sv
// Execute-to-writeback stage: holds the architectural condition codes,
// resolves conditional branches and buffers register writebacks.
module alu_result_stage
    import alu_result_stage_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    alu_result_stage_if.slave   bus,
    output logic                cc_n,
    output logic                cc_z,
    output logic                cc_p,
    output logic                br_taken,
    output logic [PC_WIDTH-1:0] br_target
);

    logic [2:0]          cc_r;
    logic                br_taken_r;
    logic [PC_WIDTH-1:0] br_target_r;
    logic                fifo_ready_s;
    logic                in_ready_s;
    logic                accept_s;
    logic                push_s;
    logic                taken_s;
    wb_entry_t           push_entry_s;
    wb_entry_t           head_s;

    // Both terms are registered, so out_ready never reaches in_ready.
    assign in_ready_s   = fifo_ready_s && !br_taken_r;
    assign accept_s     = bus.in_valid && in_ready_s;
    assign push_s       = accept_s && bus.in_we;
    assign taken_s      = accept_s && bus.in_br && br_eval(bus.in_br_mask, cc_r);
    assign push_entry_s = '{rd: bus.in_rd, data: bus.in_result};

    assign bus.in_ready = in_ready_s;
    assign bus.out_rd   = head_s.rd;
    assign bus.out_data = head_s.data;

    assign cc_n      = cc_r[BR_N];
    assign cc_z      = cc_r[BR_Z];
    assign cc_p      = cc_r[BR_P];
    assign br_taken  = br_taken_r;
    assign br_target = br_target_r;

    // Condition codes and branch resolution; the branch sees the CC from before this edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cc_r        <= CC_RESET;
            br_taken_r  <= 1'b0;
            br_target_r <= {PC_WIDTH{1'b0}};
        end else begin
            if (accept_s && bus.in_set_cc) begin
                cc_r <= {bus.in_n, bus.in_z, bus.in_p};
            end else begin
                cc_r <= cc_r;
            end
            br_taken_r <= taken_s;
            if (taken_s) begin
                br_target_r <= bus.in_br_target;
            end else begin
                br_target_r <= br_target_r;
            end
        end
    end

    wb_fifo2 #(
        .WIDTH($bits(wb_entry_t))
    ) u_wb_fifo2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_valid (push_s),
        .push_ready (fifo_ready_s),
        .push_data  (push_entry_s),
        .pop_valid  (bus.out_valid),
        .pop_ready  (bus.out_ready),
        .pop_data   (head_s)
    );

endmodule
